// File: rtl/jtag_scan_master.sv
// jtag_scan_master: turns one IR/DR scan command into a registered TMS/TDI stream and captures TDO.
module jtag_scan_master #(
  parameter int DR_MAX = 64,
  parameter int IR_LEN = 2,
  parameter int LEN_W  = 7
) (
  input  logic              TCLK,
  input  logic              TRST,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_ir,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DR_MAX-1:0] cmd_data,
  output logic              rsp_valid,
  output logic [DR_MAX-1:0] rsp_data,
  output logic              rsp_err,
  output logic              TMS,
  output logic              TDI,
  input  logic              TDO
);
  localparam int IW = $clog2(DR_MAX);
  typedef enum logic [2:0] {RST_SEQ, IDLE, PRE, SHIFT, POST, RESP} state_t;
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt, cnt_nx, len;
  logic [IW-1:0] cap_idx;
  logic [DR_MAX-1:0] sr, cap;
  logic ir, err, cap_en, accept, bad_len, last, tms_nx;
  assign accept = cmd_valid && cmd_ready;
  assign bad_len = !cmd_ir && (cmd_len == '0 || cmd_len > LEN_W'(DR_MAX));
  assign last = cnt == len - LEN_W'(1);
  // Pin values are a registered image of the current state, so every pin lags the FSM by one cycle.
  assign tms_nx = state == RST_SEQ ? cnt != LEN_W'(4)
                : state == PRE     ? cnt < (ir ? LEN_W'(2) : LEN_W'(1))
                : state == SHIFT   ? last
                : state == POST    ? cnt == '0 : 1'b0;
  always_comb begin
    state_nx = state;
    cnt_nx = cnt + LEN_W'(1);
    case (state)
      RST_SEQ: if (cnt == LEN_W'(4)) begin state_nx = IDLE; cnt_nx = '0; end
      IDLE: begin
        cnt_nx = '0;
        if (accept) state_nx = bad_len ? RESP : PRE;
      end
      PRE: if (cnt == (ir ? LEN_W'(3) : LEN_W'(2))) begin state_nx = SHIFT; cnt_nx = '0; end
      SHIFT: if (last) begin state_nx = POST; cnt_nx = '0; end
      POST: if (cnt == LEN_W'(1)) begin state_nx = RESP; cnt_nx = '0; end
      default: begin state_nx = IDLE; cnt_nx = '0; end
    endcase
  end
  always_ff @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      state <= RST_SEQ;
      cnt <= '0;
      len <= '0;
      ir <= 1'b0;
      err <= 1'b0;
      sr <= '0;
      cap <= '0;
      cap_en <= 1'b0;
      cap_idx <= '0;
      TMS <= 1'b1;
      TDI <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_err <= 1'b0;
      rsp_data <= '0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      TMS <= tms_nx;
      TDI <= state == SHIFT && sr[0];
      cmd_ready <= state == IDLE && !accept;
      rsp_valid <= state == RESP;
      rsp_err <= state == RESP && err;
      // TDO for a bit is valid at the edge that consumes it, one cycle after it was driven
      cap_en <= state == SHIFT;
      cap_idx <= cnt[IW-1:0];
      if (cap_en) cap[cap_idx] <= TDO;
      if (state == SHIFT) sr <= sr >> 1;
      if (state == RESP) rsp_data <= cap;
      if (accept) begin
        ir <= cmd_ir;
        len <= cmd_ir ? LEN_W'(IR_LEN) : cmd_len;
        err <= bad_len;
        sr <= cmd_data;
        cap <= '0;
      end
    end
  end
endmodule

// File: tb/tb_jtag_scan_master.sv
// tb_jtag_scan_master: drives scan commands into jtag_scan_master against a behavioural TAP with a loopback DR chain.
module tb_jtag_scan_master;
  localparam int DR_MAX = 64, IR_LEN = 2, LEN_W = 7;
  logic TCLK, TRST, cmd_valid, cmd_ready, cmd_ir, rsp_valid, rsp_err, TMS, TDI, TDO;
  logic [LEN_W-1:0] cmd_len;
  logic [DR_MAX-1:0] cmd_data, rsp_data;
  int pass, total;

  always begin TCLK = 1'b0; #5; TCLK = 1'b1; #5; end

  jtag_scan_master #(.DR_MAX(DR_MAX), .IR_LEN(IR_LEN), .LEN_W(LEN_W)) dut (
    .TCLK(TCLK), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir),
    .cmd_len(cmd_len), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .TMS(TMS), .TDI(TDI), .TDO(TDO));

  // IEEE 1149.1 TAP state graph, a DR chain of programmable length and a 2-bit IR
  typedef enum logic [3:0] {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                            SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  tap_t tap;
  logic [63:0] chain, load_val;
  logic load;
  int chain_len;
  logic [1:0] ir_sr, ir_reg;

  function automatic tap_t tnext(tap_t s, logic m);
    case (s)
      TLR:     return m ? TLR   : RTI;
      RTI:     return m ? SELDR : RTI;
      SELDR:   return m ? SELIR : CAPDR;
      CAPDR:   return m ? EX1DR : SHDR;
      SHDR:    return m ? EX1DR : SHDR;
      EX1DR:   return m ? UPDR  : PADR;
      PADR:    return m ? EX2DR : PADR;
      EX2DR:   return m ? UPDR  : SHDR;
      UPDR:    return m ? SELDR : RTI;
      SELIR:   return m ? TLR   : CAPIR;
      CAPIR:   return m ? EX1IR : SHIR;
      SHIR:    return m ? EX1IR : SHIR;
      EX1IR:   return m ? UPIR  : PAIR;
      PAIR:    return m ? EX2IR : PAIR;
      EX2IR:   return m ? UPIR  : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction

  assign TDO = tap == SHDR ? chain[0] : tap == SHIR ? ir_sr[0] : 1'b0;

  always @(posedge TCLK or negedge TRST) begin
    if (!TRST) begin
      tap <= TLR;
      ir_sr <= 2'b00;
      ir_reg <= 2'b00;
    end else begin
      tap <= tnext(tap, TMS);
      if (tap == CAPIR) ir_sr <= 2'b01;
      if (tap == SHIR) ir_sr <= {TDI, ir_sr[1]};
      if (tap == UPIR) ir_reg <= ir_sr;
    end
  end

  always @(posedge TCLK) begin
    if (tap == SHDR) chain <= (chain >> 1) | (64'(TDI) << (chain_len - 1));
    else if (load) chain <= load_val;
  end

  function automatic logic [63:0] msk(int l);
    return l >= 64 ? '1 : (64'd1 << l) - 64'd1;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic preload(input int l, input logic [63:0] v);
    chain_len = l;
    load_val = v & msk(l);
    load = 1'b1;
    @(negedge TCLK);
    load = 1'b0;
  endtask

  // Issue one command from a negedge; lat = posedges from accept until rsp_valid is visible.
  task automatic scan(input logic ir, input int l, input logic [63:0] d, output logic [63:0] rd,
                      output logic re, output int lat, output int ones, output logic extra);
    int n;
    n = 0;
    while (!cmd_ready && n < 200) begin @(negedge TCLK); n++; end
    cmd_ir = ir; cmd_len = LEN_W'(l); cmd_data = d; cmd_valid = 1'b1;
    @(negedge TCLK);
    cmd_valid = 1'b0;
    lat = 0; ones = 0;
    while (!rsp_valid && lat < 200) begin ones += int'(TMS); @(negedge TCLK); lat++; end
    rd = rsp_data; re = rsp_err;
    @(negedge TCLK);
    extra = rsp_valid;
  endtask

  typedef struct {
    logic ir; int len; logic [63:0] data; logic [63:0] init;
    logic [63:0] exp_rsp; logic exp_err; int exp_lat; int exp_ones; logic [63:0] exp_after;
  } vec_t;
  vec_t tbl[7];

  task automatic run_one(input string nm, input vec_t v);
    logic [63:0] rd; logic re, extra; int lat, ones;
    preload((v.ir || v.exp_err) ? 8 : v.len, v.init);
    scan(v.ir, v.len, v.data, rd, re, lat, ones, extra);
    chk({nm, " rsp_data"}, rd, v.exp_rsp);
    chk({nm, " rsp_err"}, 64'(re), 64'(v.exp_err));
    chk({nm, " latency"}, 64'(lat), 64'(v.exp_lat));
    chk({nm, " tms_ones"}, 64'(ones), 64'(v.exp_ones));
    chk({nm, " pulse_len"}, 64'(extra), 64'd0);
    chk({nm, " tap_rti"}, 64'(tap), 64'(RTI));
    chk({nm, " after"}, v.ir ? 64'(ir_reg) : chain, v.exp_after);
  endtask

  initial begin
    logic [63:0] rd; logic re, extra, seen; int lat, ones, rdy_at;
    int acc_q[$], rsp_q[$]; logic [63:0] rd_q[$];
    pass = 0; total = 0;
    TRST = 1'b0; cmd_valid = 1'b0; cmd_ir = 1'b0; cmd_len = '0; cmd_data = '0;
    load = 1'b0; load_val = '0; chain_len = 8;
    repeat (3) @(negedge TCLK);
    chk("rst TMS", 64'(TMS), 64'd1);
    chk("rst TDI", 64'(TDI), 64'd0);
    chk("rst cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst rsp_err", 64'(rsp_err), 64'd0);
    chk("rst rsp_data", rsp_data, 64'd0);
    TRST = 1'b1;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("seq%0d TMS", k), 64'(TMS), 64'(k < 5));
      chk($sformatf("seq%0d cmd_ready", k), 64'(cmd_ready), 64'(k >= 6));
      @(negedge TCLK);
    end
    chk("seq tap_rti", 64'(tap), 64'(RTI));
    TRST = 1'b0;
    @(negedge TCLK);
    TRST = 1'b1;
    repeat (5) @(negedge TCLK);
    chk("midseq TMS before", 64'(TMS), 64'd0);
    TRST = 1'b0;
    #1;
    chk("midseq TMS async", 64'(TMS), 64'd1);
    chk("midseq cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge TCLK);
    TRST = 1'b1;
    repeat (7) @(negedge TCLK);
    chk("midseq ready", 64'(cmd_ready), 64'd1);

    tbl[0] = '{1'b1, 0, 64'h2, 64'h0, 64'h1, 1'b0, 9, 4, 64'h2};
    tbl[1] = '{1'b0, 8, 64'hA5, 64'h3C, 64'h3C, 1'b0, 14, 3, 64'hA5};
    tbl[2] = '{1'b0, 1, 64'h1, 64'h0, 64'h0, 1'b0, 7, 3, 64'h1};
    tbl[3] = '{1'b0, 1, 64'h0, 64'h1, 64'h1, 1'b0, 7, 3, 64'h0};
    tbl[4] = '{1'b0, 64, 64'hDEADBEEF01234567, 64'hF0E1D2C3B4A59687, 64'hF0E1D2C3B4A59687, 1'b0, 70, 3, 64'hDEADBEEF01234567};
    tbl[5] = '{1'b0, 0, 64'hFF, 64'h55, 64'h0, 1'b1, 1, 0, 64'h55};
    tbl[6] = '{1'b0, 65, 64'hFF, 64'h55, 64'h0, 1'b1, 1, 0, 64'h55};
    foreach (tbl[i]) run_one($sformatf("vec%0d", i), tbl[i]);

    for (int i = 0; i < 24; i++) begin
      vec_t v;
      v.ir = $urandom_range(3) == 0;
      v.len = $urandom_range(9) == 0 ? ($urandom_range(1) == 0 ? 0 : int'($urandom_range(127, 65)))
                                     : int'($urandom_range(64, 1));
      v.data = {$urandom, $urandom};
      v.init = {$urandom, $urandom};
      v.exp_err = !v.ir && (v.len == 0 || v.len > DR_MAX);
      v.exp_rsp = v.exp_err ? 64'd0 : v.ir ? 64'h1 : v.init & msk(v.len);
      v.exp_lat = v.exp_err ? 1 : v.ir ? IR_LEN + 7 : v.len + 6;
      v.exp_ones = v.exp_err ? 0 : v.ir ? 4 : 3;
      v.exp_after = v.exp_err ? v.init & msk(8) : v.ir ? v.data & msk(IR_LEN) : v.data & msk(v.len);
      run_one($sformatf("rnd%0d", i), v);
    end

    preload(4, 64'h9);
    cmd_ir = 1'b0; cmd_len = LEN_W'(4); cmd_data = 64'h6; cmd_valid = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (rsp_valid) begin rsp_q.push_back(c); rd_q.push_back(rsp_data); end
      if (rsp_q.size() == 3) break;
      if (cmd_ready) acc_q.push_back(c);
      @(negedge TCLK);
    end
    cmd_valid = 1'b0;
    chk("hs accepts", 64'(acc_q.size()), 64'd3);
    chk("hs responses", 64'(rsp_q.size()), 64'd3);
    if (acc_q.size() == 3 && rsp_q.size() == 3) begin
      chk("hs period", 64'(acc_q[1] - acc_q[0]), 64'd12);
      chk("hs latency", 64'(rsp_q[0] - acc_q[0]), 64'd11);
      chk("hs reaccept", 64'(acc_q[2] - rsp_q[1]), 64'd1);
      chk("hs rsp0", rd_q[0], 64'h9);
      chk("hs rsp1", rd_q[1], 64'h6);
    end
    @(negedge TCLK);

    preload(16, 64'h1234);
    cmd_ir = 1'b0; cmd_len = LEN_W'(16); cmd_data = 64'hBEEF; cmd_valid = 1'b1;
    @(negedge TCLK);
    cmd_valid = 1'b0;
    repeat (8) @(negedge TCLK);
    chk("abort in shift", 64'(tap), 64'(SHDR));
    TRST = 1'b0;
    seen = 1'b0;
    repeat (3) begin @(negedge TCLK); seen |= rsp_valid; end
    TRST = 1'b1;
    rdy_at = -1;
    for (int k = 0; k < 12; k++) begin
      seen |= rsp_valid;
      if (cmd_ready && rdy_at < 0) rdy_at = k;
      @(negedge TCLK);
    end
    chk("abort no rsp", 64'(seen), 64'd0);
    chk("abort ready at", 64'(rdy_at), 64'd6);
    chk("abort tap_rti", 64'(tap), 64'(RTI));
    preload(16, 64'hC0DE);
    scan(1'b0, 16, 64'h5A5A, rd, re, lat, ones, extra);
    chk("post-abort rsp", rd, 64'hC0DE);
    chk("post-abort err", 64'(re), 64'd0);
    chk("post-abort latency", 64'(lat), 64'd22);
    chk("post-abort chain", chain, 64'h5A5A);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", pass, total);
    $fatal(1);
  end
endmodule

// File: doc/jtag_scan_master.md
# jtag_scan_master

The JTAG scan master turns one scan command (an IR scan or a DR scan of N bits) into a cycle-accurate TMS/TDI bit stream. That stream drives the TMS/TDI pins of the s9234 JTAG top level, and the block samples TDO back into a response word. It sits directly upstream of the TAP controller and boundary-scan chain, in the test harness and board-level wrapper. It lets software- or testbench-level sequencers issue whole scans instead of toggling pins.

## Interface
Parameters:
- DR_MAX, 64: maximum DR scan length in bits; also the width of the data and response buses.
- IR_LEN, 2: instruction register length in bits. IR scans always shift exactly IR_LEN bits.
- LEN_W, 7: width of cmd_len. Must satisfy 2^LEN_W > DR_MAX.

Ports:
- TCLK, in, 1: scan clock, the single clock of the block. All state updates on the rising edge.
- TRST, in, 1: asynchronous active-low reset.
- cmd_valid, in, 1: a command is present.
- cmd_ready, out, 1: the master can accept a command. The command transfers on a rising edge where cmd_valid & cmd_ready.
- cmd_ir, in, 1: 1 = IR scan, 0 = DR scan.
- cmd_len, in, LEN_W: DR scan length in bits. Ignored for IR scans.
- cmd_data, in, DR_MAX: bits to shift in, LSB first. For IR scans only [IR_LEN-1:0] is used.
- rsp_valid, out, 1: one-cycle pulse; the response is present.
- rsp_data, out, DR_MAX: TDO bits captured during the shift, LSB = first bit. Unused upper bits are 0.
- rsp_err, out, 1: qualifies rsp_valid. 1 = illegal length, no scan performed.
- TMS, out, 1: registered; drives the TAP TMS.
- TDI, out, 1: registered; drives the TAP TDI.
- TDO, in, 1: from the TAP TDO.

## Operation
FSM states: RST_SEQ, IDLE, PRE, SHIFT, POST, RESP.

- **Reset (TRST low):**
  - State goes to RST_SEQ.
  - TMS=1, TDI=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0.
  - Counters are cleared.
- **RST_SEQ:** after TRST rises, drive TMS=1 for 5 cycles, then TMS=0 for 1 cycle. The TAP is then in Run-Test/Idle. Go to IDLE.
- **IDLE:**
  - TMS=0, TDI=0, cmd_ready=1.
  - On acceptance, latch cmd_ir, the length and cmd_data into a shift register, clear the capture register, deassert cmd_ready, and go to PRE.
  - Length is IR_LEN when cmd_ir=1, otherwise cmd_len.
- **Illegal length:** a DR command with cmd_len==0 or cmd_len>DR_MAX goes straight to RESP with rsp_err=1. No TMS activity occurs.
- **PRE:** emit the TMS prefix, one value per cycle, with TDI=0.
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0 (Select-DR, Select-IR, Capture-IR, Shift-IR).
- **SHIFT:** one bit per cycle for len cycles.
  - TDI = current shift-register LSB.
  - TMS=0, except TMS=1 on the last bit so the TAP moves to Exit1.
  - On the edge that consumes bit i, sample TDO into capture bit i, then shift the register right.
- **POST:** TMS=1 (Update), then TMS=0 (Run-Test/Idle), with TDI=0.
- **RESP:**
  - rsp_valid=1 for exactly one cycle.
  - rsp_data = capture register, zero-extended above len.
  - Return to IDLE; cmd_ready reasserts on the following cycle.
- rsp_data holds its value until the next RESP. rsp_err is meaningful only while rsp_valid=1.
- There is no response backpressure: the consumer must take rsp_valid when it pulses.
- cmd_valid is ignored outside IDLE; commands presented while busy are not queued.
- **TRST mid-scan:** the scan is abandoned immediately with no rsp_valid, and the FSM restarts RST_SEQ.

## Timing
- TMS and TDI are registered outputs. A value driven after edge k is consumed by the TAP at edge k+1.
- TDO is sampled at that same consuming edge, so it reflects the TAP output before the shift.
- Accept edge to first TMS=1 of the prefix: 1 cycle.
- DR scan occupies len+5 TMS cycles; IR scan occupies IR_LEN+6.
- rsp_valid asserts in the cycle after the final POST value (TMS=0) has been driven.
- Accept to rsp_valid: len+6 cycles for DR, IR_LEN+7 for IR.
- Command throughput: one command per len+8 cycles for DR scans.
- An illegal-length command gives rsp_valid exactly 1 cycle after acceptance.
- After TRST deassertion, cmd_ready first rises 6 cycles later.

## Test plan
- **Reset sequence:** release TRST → TMS = 1,1,1,1,1,0, then cmd_ready=1 with TMS held 0. Re-assert TRST mid-sequence → outputs return to reset values immediately.
- **IR scan:** data=2'b10; bench TAP model TDO captures 2'b01 → TMS 1,1,0,0,0,1,1,0 and TDI shift bits 0,1. rsp_valid after 9 cycles with rsp_data=0x1, rsp_err=0.
- **DR scan with loopback:** len=8, data=0xA5, bench 8-bit shift register preloaded 0x3C → TDI bits 1,0,1,0,0,1,0,1 and rsp_data=0x3C. Loopback register ends at 0xA5.
- **Length boundaries:**
  - len=1 → single shift cycle with TMS=1.
  - len=DR_MAX → all 64 bits round-trip.
  - len=0 and len=DR_MAX+1 → rsp_err=1 one cycle after accept, TMS stays 0.
- **Handshake:** cmd_valid held high during a scan → no second acceptance until IDLE. Back-to-back commands are accepted exactly one cycle after each rsp_valid.
- **TRST mid-scan:** TRST pulsed low during SHIFT of a len=16 DR scan → no rsp_valid, RST_SEQ restarts, and the next command completes correctly.
